// File: rtl/sram_controller_pkg.sv
// Shared definitions for the half-word SRAM access sequencer.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    SRAM_IDLE = 2'd0,
    SRAM_LOW  = 2'd1,
    SRAM_HIGH = 2'd2,
    SRAM_DONE = 2'd3
  } sram_state_t;

  localparam int DEF_BASE_ADDR   = 1024;
  localparam int DEF_SRAM_ADDR_W = 18;
  localparam int DEF_WAIT_CYCLES = 1;

endpackage

// File: rtl/sram_wait_counter.sv
// Phase-length counter: counts 0..WAIT_CYCLES within one SRAM phase.
// tc marks the last cycle of a phase, pre_tc the cycle just before it.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic inc,
  output logic tc,
  output logic pre_tc
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [CW-1:0] count;

  // Clear on load (phase entry / exit), otherwise step through the phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end

  assign tc     = (count == CW'(WAIT_CYCLES));
  assign pre_tc = (WAIT_CYCLES > 0) && (count == CW'(WAIT_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Sequences 32-bit LDR/STR accesses onto a 16-bit SRAM as two half-word
// phases (low half first) and holds the pipeline via ready until done.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int BASE_ADDR   = DEF_BASE_ADDR,
  parameter int SRAM_ADDR_W = DEF_SRAM_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n
);

  // With a single-cycle phase there is no room to drop the strobe before
  // the phase ends, so the strobe is only pulsed when phases are stretched.
  localparam bit STROBE = (WAIT_CYCLES > 0);

  sram_state_t            state;
  logic                   op_wr;
  logic [SRAM_ADDR_W-2:0] word_q;
  logic [31:0]            wdata_q;

  logic                   req;
  logic                   in_phase;
  logic                   tc;
  logic                   pre_tc;
  logic [31:0]            offset;
  logic [SRAM_ADDR_W-2:0] word_in;
  logic                   unused_offset_bits;

  assign req      = rd_en | wr_en;
  assign in_phase = (state == SRAM_LOW) || (state == SRAM_HIGH);
  assign ready    = !req || (state == SRAM_DONE);

  // Addresses below BASE_ADDR simply wrap; only the word bits are kept.
  assign offset             = address - 32'(BASE_ADDR);
  assign word_in            = offset[SRAM_ADDR_W:2];
  assign unused_offset_bits = ^{offset[31:SRAM_ADDR_W+1], offset[1:0]};

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait (
    .clk   (clk),
    .rst   (rst),
    .load  (((state == SRAM_IDLE) && req) || (in_phase && tc)),
    .inc   (in_phase && !tc),
    .tc    (tc),
    .pre_tc(pre_tc)
  );

  // Transaction payload captured when leaving IDLE; later input changes are ignored.
  always_ff @(posedge clk) begin
    if ((state == SRAM_IDLE) && req) begin
      word_q  <= word_in;
      wdata_q <= write_data;
    end
  end

  // Access FSM with registered SRAM pin drive and read-data capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SRAM_IDLE;
      op_wr       <= 1'b0;
      read_data   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_oe  <= 1'b0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
    end else begin
      case (state)
        SRAM_IDLE: begin
          if (req) begin
            state       <= SRAM_LOW;
            op_wr       <= wr_en;
            sram_addr   <= {word_in, 1'b0};
            sram_dq_oe  <= wr_en;
            sram_dq_out <= write_data[15:0];
            sram_we_n   <= !(wr_en && STROBE);
          end
        end
        SRAM_LOW: begin
          if (tc) begin
            if (!op_wr) read_data[15:0] <= sram_dq_in;
            state       <= SRAM_HIGH;
            sram_addr   <= {word_q, 1'b1};
            sram_dq_out <= wdata_q[31:16];
            sram_we_n   <= !(op_wr && STROBE);
          end else if (pre_tc) begin
            sram_we_n <= 1'b1;
          end
        end
        SRAM_HIGH: begin
          if (tc) begin
            if (!op_wr) read_data[31:16] <= sram_dq_in;
            state      <= SRAM_DONE;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
          end else if (pre_tc) begin
            sram_we_n <= 1'b1;
          end
        end
        SRAM_DONE: state <= SRAM_IDLE;
        default:   state <= SRAM_IDLE;
      endcase
    end
  end

endmodule
